// File: rtl/instr_fetch_fsm_pkg.sv
// Shared opcode constants, instruction layout and state encoding for the fetch sequencer.
// No timing of its own; no flow control.
package instr_fetch_fsm_pkg;

  localparam logic [3:0] OPC_NOP  = 4'b0000;
  localparam logic [3:0] OPC_ADD  = 4'b0001;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam int OP_LSB = 12;
  localparam int P1_LSB = 6;
  localparam int P2_LSB = 0;

  // para fields are one-hot register selects; all-ones means "no register"
  localparam logic [5:0] NO_REG = 6'b111111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_F_ADDR = 4'd1,
    ST_F_WAIT = 4'd2,
    ST_DECODE = 4'd3,
    ST_ISSUE  = 4'd4,
    ST_EXEC   = 4'd5,
    ST_HALT   = 4'd6
  } fetch_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] p1;
    logic [5:0] p2;
  } instr_t;

  function automatic instr_t split_instr(input logic [15:0] word);
    instr_t f;
    f.op = word[OP_LSB +: 4];
    f.p1 = word[P1_LSB +: 6];
    f.p2 = word[P2_LSB +: 6];
    return f;
  endfunction

endpackage

// File: rtl/instr_fetch_fsm_pc_counter.sv
// Program counter: synchronous clear, increment on enable, silent wrap modulo 2^PC_W.
// Latency: new value visible the cycle after i_inc; never stalls.
module instr_fetch_fsm_pc_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_fsm.sv
// Fetch/decode sequencer: reads imem, splits opcode/para1/para2, pulses start, waits for fetch.
// Latency: run (IDLE) or fetch (EXEC) to start is 4 cycles; holds in EXEC until fetch or watchdog expiry.
module instr_fetch_fsm
  import instr_fetch_fsm_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter int         TIMEOUT = 32,
  parameter logic [3:0] NOP_OP  = OPC_NOP,
  parameter logic [3:0] HALT_OP = OPC_HALT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imemAddr,
  output logic            imemRead,
  input  logic [15:0]     imemData,
  output logic            start,
  output logic [3:0]      opCode,
  output logic [5:0]      para1,
  output logic [5:0]      para2,
  input  logic            incr,
  input  logic            fetch,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [PC_W-1:0] pc
);

  localparam int             WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  fetch_state_e    r_state;
  fetch_state_e    w_next;
  logic [15:0]     r_ir;
  logic [3:0]      r_op;
  logic [5:0]      r_p1;
  logic [5:0]      r_p2;
  logic [WD_W-1:0] r_wdog;
  logic            r_error;
  logic            w_pc_inc;
  logic            w_wd_expire;
  logic [PC_W-1:0] w_pc;
  instr_t          w_dec;

  assign w_dec       = split_instr(r_ir);
  assign w_wd_expire = (r_wdog == WD_LAST);

  instr_fetch_fsm_pc_counter #(.PC_W(PC_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_pc_inc),
    .o_pc  (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_op    <= 4'b0000;
      r_p1    <= NO_REG;
      r_p2    <= NO_REG;
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_F_WAIT) r_ir <= imemData;
      // Decoded fields are held until the next DECODE so the execute FSM can read them combinationally.
      if (r_state == ST_DECODE) begin
        r_op <= w_dec.op;
        r_p1 <= w_dec.p1;
        r_p2 <= w_dec.p2;
      end
      if (r_state == ST_ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == ST_EXEC) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      if (r_state == ST_EXEC && !fetch && w_wd_expire) r_error <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pc_inc = 1'b0;
    case (r_state)
      ST_IDLE:   if (run) w_next = ST_F_ADDR;
      ST_F_ADDR: w_next = ST_F_WAIT;
      ST_F_WAIT: w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_dec.op == HALT_OP) begin
          w_next = ST_HALT;
        end else if (w_dec.op == NOP_OP) begin
          w_pc_inc = 1'b1;
          w_next   = run ? ST_F_ADDR : ST_IDLE;
        end else begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE:  w_next = ST_EXEC;
      ST_EXEC: begin
        w_pc_inc = incr;
        if (fetch) begin
          w_next = run ? ST_F_ADDR : ST_IDLE;
        end else if (w_wd_expire) begin
          w_next = ST_HALT;
        end
      end
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign imemAddr = w_pc;
  assign pc       = w_pc;
  assign imemRead = (r_state == ST_F_ADDR) || (r_state == ST_F_WAIT);
  assign start    = (r_state == ST_ISSUE);
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted   = (r_state == ST_HALT);
  assign error    = r_error;
  assign opCode   = r_op;
  assign para1    = r_p1;
  assign para2    = r_p2;

endmodule

// File: tb/tb_instr_fetch_fsm.sv
// Bench for instr_fetch_fsm: imem model plus an execute-FSM model; expectations come from
// instruction-level timing rules (start 4 cycles after run/fetch, +3 per skipped NOP).
module tb_instr_fetch_fsm;
  import instr_fetch_fsm_pkg::*;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        reset, run, incr, fetch;
  logic        imemRead, start, busy, halted, error;
  logic [7:0]  imemAddr, pc;
  logic [15:0] imemData;
  logic [3:0]  opCode;
  logic [5:0]  para1, para2;
  logic [15:0] imem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  instr_fetch_fsm #(.PC_W(PC_W), .TIMEOUT(TIMEOUT), .NOP_OP(4'b0000), .HALT_OP(4'b1111)) dut (
    .clk(clk), .reset(reset), .run(run), .imemAddr(imemAddr), .imemRead(imemRead),
    .imemData(imemData), .start(start), .opCode(opCode), .para1(para1), .para2(para2),
    .incr(incr), .fetch(fetch), .busy(busy), .halted(halted), .error(error), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imemRead) imemData <= imem[imemAddr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; run = 1'b0; incr = 1'b0; fetch = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  // Caller has already clocked the triggering cycle, so the current cycle is number 1.
  task automatic wait_start(input int limit, input bit noise, output int c);
    c = 1;
    while (!start && c < limit) begin
      if (noise) begin
        incr  = 1'($urandom_range(0, 1));
        fetch = 1'($urandom_range(0, 1));
      end
      tick;
      incr = 1'b0; fetch = 1'b0;
      c++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if ({busy, halted, error, start, imemRead} !== 5'b00000) begin n_fail++;
      $display("FAIL reset_flags: busy/halted/error/start/imemRead=%b want 00000", {busy, halted, error, start, imemRead}); end
    n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_checks++; if ({opCode, para1, para2} !== 16'h0FFF) begin n_fail++;
      $display("FAIL reset_fields: got %h want 0fff", {opCode, para1, para2}); end
    for (int i = 0; i < 6; i++) begin
      incr = 1'b1; fetch = 1'b1;
      tick;
      n_checks++; if (pc !== 8'h00 || busy !== 1'b0) begin n_fail++;
        $display("FAIL idle_ignore: pc=%h busy=%b want 00/0", pc, busy); end
    end
    incr = 1'b0; fetch = 1'b0;
  endtask

  task automatic test_first_fetch;
    do_reset;
    imem[0] = 16'h1084; imem[1] = 16'h2042;
    run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      n_checks++; if (start !== 1'(k == 4) || imemRead !== 1'(k <= 2)) begin n_fail++;
        $display("FAIL first_seq c%0d: start=%b imemRead=%b want %b/%b", k, start, imemRead, k == 4, k <= 2); end
      if (k == 1) begin
        n_checks++; if (imemAddr !== 8'h00) begin n_fail++; $display("FAIL first_addr: got %h want 00", imemAddr); end
      end
    end
    n_checks++; if ({opCode, para1, para2} !== 16'h1084) begin n_fail++;
      $display("FAIL first_fields: got %h want 1084", {opCode, para1, para2}); end
  endtask

  // Continues from test_first_fetch, currently in the ISSUE cycle.
  task automatic test_exec_handshake;
    int c;
    tick;
    for (int e = 1; e <= 9; e++) begin
      incr = 1'(e == 1); fetch = 1'(e == 9);
      n_checks++; if (start !== 1'b0 || busy !== 1'b1 || {opCode, para1, para2} !== 16'h1084) begin n_fail++;
        $display("FAIL exec_hold e%0d: start=%b busy=%b fields=%h want 0/1/1084", e, start, busy, {opCode, para1, para2}); end
      tick;
      incr = 1'b0; fetch = 1'b0;
    end
    n_checks++; if (pc !== 8'h01 || imemAddr !== 8'h01 || imemRead !== 1'b1) begin n_fail++;
      $display("FAIL exec_next_addr: pc=%h addr=%h rd=%b want 01/01/1", pc, imemAddr, imemRead); end
    wait_start(20, 1'b0, c);
    n_checks++; if (c !== 4 || start !== 1'b1) begin n_fail++; $display("FAIL exec_restart: latency=%0d want 4", c); end
    n_checks++; if ({opCode, para1, para2} !== 16'h2042) begin n_fail++;
      $display("FAIL exec_fields2: got %h want 2042", {opCode, para1, para2}); end
  endtask

  task automatic test_nop;
    do_reset;
    imem[0] = 16'h0000; imem[1] = 16'h1084;
    run = 1'b1;
    tick;
    for (int c = 1; c <= 7; c++) begin
      n_checks++; if (start !== 1'(c == 7)) begin n_fail++; $display("FAIL nop_start c%0d: got %b want %b", c, start, c == 7); end
      if (c == 4) begin
        n_checks++; if (imemAddr !== 8'h01 || imemRead !== 1'b1) begin n_fail++;
          $display("FAIL nop_refetch: addr=%h rd=%b want 01/1", imemAddr, imemRead); end
      end
      if (c < 7) tick;
    end
    n_checks++; if (pc !== 8'h01 || {opCode, para1, para2} !== 16'h1084) begin n_fail++;
      $display("FAIL nop_result: pc=%h fields=%h want 01/1084", pc, {opCode, para1, para2}); end
  endtask

  task automatic test_halt;
    do_reset;
    imem[0] = 16'hF000; imem[1] = 16'h1084;
    run = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      n_checks++; if (halted !== 1'(c == 4) || start !== 1'b0) begin n_fail++;
        $display("FAIL halt_entry c%0d: halted=%b start=%b want %b/0", c, halted, start, c == 4); end
    end
    n_checks++; if (opCode !== 4'hF) begin n_fail++; $display("FAIL halt_opcode: got %h want f", opCode); end
    for (int i = 0; i < 50; i++) begin
      run = 1'($urandom_range(0, 1)); incr = 1'($urandom_range(0, 1)); fetch = 1'($urandom_range(0, 1));
      tick;
      n_checks++; if ({halted, busy, imemRead, start} !== 4'b1000 || pc !== 8'h00) begin n_fail++;
        $display("FAIL halt_hold i%0d: h/b/rd/st=%b pc=%h want 1000/00", i, {halted, busy, imemRead, start}, pc); end
    end
    do_reset;
    n_checks++; if (halted !== 1'b0 || busy !== 1'b0 || pc !== 8'h00) begin n_fail++;
      $display("FAIL halt_reset: halted=%b busy=%b pc=%h want 0/0/00", halted, busy, pc); end
  endtask

  task automatic test_timeout;
    int c;
    logic [7:0] pc_hold;
    do_reset;
    imem[0] = {OPC_ADD, 12'($urandom)};
    run = 1'b1;
    tick;
    wait_start(20, 1'b1, c);
    n_checks++; if (c !== 4) begin n_fail++; $display("FAIL to_start: latency=%0d want 4", c); end
    tick;
    for (int e = 1; e <= TIMEOUT; e++) begin
      n_checks++; if ({halted, error, busy} !== 3'b001) begin n_fail++;
        $display("FAIL to_exec e%0d: halted/error/busy=%b want 001", e, {halted, error, busy}); end
      tick;
    end
    n_checks++; if ({halted, error, busy} !== 3'b110) begin n_fail++;
      $display("FAIL to_expire: halted/error/busy=%b want 110", {halted, error, busy}); end
    pc_hold = pc;
    for (int i = 0; i < 10; i++) begin
      incr = 1'b1; fetch = 1'($urandom_range(0, 1)); run = 1'($urandom_range(0, 1));
      tick;
      n_checks++; if (pc !== pc_hold || halted !== 1'b1 || error !== 1'b1) begin n_fail++;
        $display("FAIL to_halt_ignore: pc=%h halted=%b error=%b want %h/1/1", pc, halted, error, pc_hold); end
    end
    do_reset;
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL to_reset_error: got %b want 0", error); end
  endtask

  task automatic test_timeout_edge;
    int c;
    do_reset;
    imem[0] = 16'h1084;
    run = 1'b1;
    tick;
    wait_start(20, 1'b0, c);
    tick;
    for (int e = 1; e <= TIMEOUT; e++) begin
      fetch = 1'(e == TIMEOUT);
      tick;
      fetch = 1'b0;
    end
    n_checks++; if ({error, halted, imemRead} !== 3'b001) begin n_fail++;
      $display("FAIL to_edge_fetch: error/halted/rd=%b want 001", {error, halted, imemRead}); end
  endtask

  task automatic test_wrap;
    int c;
    do_reset;
    for (int i = 0; i < 255; i++) imem[i] = 16'h0000;
    imem[255] = 16'h1084;
    run = 1'b1;
    tick;
    wait_start(2000, 1'b0, c);
    n_checks++; if (c !== 4 + 3 * 255 || pc !== 8'hFF) begin n_fail++;
      $display("FAIL wrap_reach: latency=%0d pc=%h want %0d/ff", c, pc, 4 + 3 * 255); end
    tick;
    incr = 1'b1; fetch = 1'b1;
    tick;
    incr = 1'b0; fetch = 1'b0;
    n_checks++; if (pc !== 8'h00 || imemAddr !== 8'h00 || imemRead !== 1'b1) begin n_fail++;
      $display("FAIL wrap_result: pc=%h addr=%h rd=%b want 00/00/1", pc, imemAddr, imemRead); end
  endtask

  task automatic test_reset_mid_exec;
    int c;
    do_reset;
    imem[0] = 16'h1084;
    run = 1'b1;
    tick;
    wait_start(20, 1'b0, c);
    tick;
    incr = 1'b1; tick; tick; incr = 1'b0;
    reset = 1'b1;
    tick;
    n_checks++; if ({busy, halted, start, imemRead} !== 4'b0000 || pc !== 8'h00) begin n_fail++;
      $display("FAIL midreset_state: b/h/st/rd=%b pc=%h want 0000/00", {busy, halted, start, imemRead}, pc); end
    n_checks++; if ({opCode, para1, para2} !== 16'h0FFF) begin n_fail++;
      $display("FAIL midreset_fields: got %h want 0fff", {opCode, para1, para2}); end
    reset = 1'b0;
  endtask

  task automatic test_random_program;
    int c, n, d, exp_pc;
    logic [15:0] w;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      w[15:12] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 14));
      w[11:0]  = 12'($urandom);
      imem[i] = w;
    end
    exp_pc = 0;
    run = 1'b1;
    tick;
    for (int it = 0; it < 25; it++) begin
      n = 0;
      w = imem[exp_pc];
      while (w[15:12] == 4'h0 && n < 256) begin
        exp_pc = (exp_pc + 1) % 256; n++;
        w = imem[exp_pc];
      end
      wait_start(4 + 3 * n + 10, 1'b1, c);
      n_checks++; if (c !== 4 + 3 * n || start !== 1'b1) begin n_fail++;
        $display("FAIL rnd_latency it%0d: got %0d want %0d", it, c, 4 + 3 * n); end
      n_checks++; if (pc !== 8'(exp_pc) || {opCode, para1, para2} !== imem[exp_pc]) begin n_fail++;
        $display("FAIL rnd_decode it%0d: pc=%h fields=%h want %h/%h", it, pc, {opCode, para1, para2}, 8'(exp_pc), imem[exp_pc]); end
      w = imem[exp_pc];
      tick;
      d = $urandom_range(1, 12);
      for (int e = 1; e <= d; e++) begin
        incr  = 1'($urandom_range(0, 1));
        fetch = 1'(e == d);
        if (e == d && $urandom_range(0, 4) == 0) run = 1'b0;
        if (incr) exp_pc = (exp_pc + 1) % 256;
        n_checks++; if ({opCode, para1, para2} !== w || start !== 1'b0) begin n_fail++;
          $display("FAIL rnd_hold it%0d e%0d: fields=%h start=%b want %h/0", it, e, {opCode, para1, para2}, start, w); end
        tick;
        incr = 1'b0; fetch = 1'b0;
      end
      if (!run) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle it%0d: busy=%b want 0", it, busy); end
        run = 1'b1;
        tick;
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; incr = 1'b0; fetch = 1'b0;
    test_reset;
    test_first_fetch;
    test_exec_handshake;
    test_nop;
    test_halt;
    test_timeout;
    test_timeout_edge;
    test_wrap;
    test_reset_mid_exec;
    test_random_program;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
